target_locator: RTL and testbench
=================================

Name: target_locator

Overview:
- Consumes the per-pixel orange-detect flag from the colour-threshold stage, in the camera pixel stream.
- Tracks pixel coordinates and accumulates, per frame:
  - orange-pixel count
  - coordinate sums
  - bounding box
- At end of frame, computes the integer centroid with a serial divider.
- Publishes one result record per frame to the downstream controller (overlay/servo logic).

Parameters:
- WIDTH, 320, active pixels per line.
- HEIGHT, 240, active lines per frame.
- MIN_PIXELS, 16, minimum orange count for a valid target.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  pixel present this cycle; no backpressure, always accepted.
- pix_sop  in  1  first pixel of frame; qualified by pix_valid.
- pix_eop  in  1  last pixel of frame; qualified by pix_valid.
- is_orange  in  1  threshold result for this pixel.
- result_valid  out  1  one-cycle pulse when a new result is loaded.
- target_found  out  1  count >= MIN_PIXELS.
- centroid_x  out  X_W  floor(sum_x/count).
- centroid_y  out  Y_W  floor(sum_y/count).
- bbox_x_min, bbox_x_max  out  X_W  bounding box columns.
- bbox_y_min, bbox_y_max  out  Y_W  bounding box rows.
- pixel_count  out  CNT_W  orange pixels in the frame.
- overrun  out  1  one-cycle pulse: frame ended while the divider was busy; that frame is dropped.

Behaviour:
- **Reset:** all outputs 0; x = y = 0; accumulators cleared; divider FSM in IDLE.
- **Coordinate tracking:** only on pix_valid.
  - sop pixel is (0,0).
  - Otherwise x increments; at x = WIDTH-1, x wraps to 0 and y increments.
  - y saturates at HEIGHT-1.
  - pix_valid low: everything holds.
- **Accumulation:** on a valid pixel with is_orange:
  - count += 1; sum_x += x; sum_y += y.
  - Min/max registers updated.
- **Frame start:** a sop pixel starts a fresh frame.
  - Accumulators reload from that pixel alone: count = is_orange, sums 0, min/max = (0,0) if orange.
  - An unfinished prior frame is silently discarded.
  - Frame-start min values are WIDTH-1 / HEIGHT-1; max values are 0.
- **End of frame:** on the eop pixel (including that pixel's own contribution):
  - If the divider is IDLE: snapshot count, sums and bbox into operand registers on the next edge, and clear the accumulators. A sop on the very next cycle is legal.
  - If the divider is busy: assert overrun, leave the snapshot untouched, clear the accumulators.
- **Divider FSM:** IDLE -> DIVIDE -> DONE -> IDLE.
  - IDLE -> DONE directly when the snapshot count < MIN_PIXELS (no divide).
  - Otherwise DIVIDE runs SUM_W cycles: two restoring dividers in parallel, one quotient bit per cycle, MSB first.
  - DONE lasts one cycle. It loads all output registers and pulses result_valid.
- **Latency:** eop accepted at cycle T.
  - Result at T+2 when below threshold.
  - Result at T+2+SUM_W when a divide runs.
- **Below-threshold result:** target_found = 0; centroids and bbox = 0; pixel_count = true count.
- **Output hold:** outputs hold their last values between result_valid pulses.
- **Simultaneous sop+eop** (1-pixel frame): treated as a complete frame.
- **Reset mid-divide:** aborts the divide; no result_valid is issued.
- **Width rules:**
  - Quotient truncated to X_W/Y_W. It is provably < WIDTH/HEIGHT, so no overflow.
  - Sums sized so that no wrap can occur.

Decomposition:
- Package target_locator_pkg:
  - X_W = $clog2(WIDTH), Y_W = $clog2(HEIGHT), CNT_W = $clog2(WIDTH*HEIGHT+1).
  - SUM_W = $clog2(WIDTH*HEIGHT*(WIDTH-1)+1).
  - Divider state enum (IDLE, DIVIDE, DONE).
  - Packed struct for the result record.
- Sub-module serial_divider:
  - Parameter W.
  - Ports: start, dividend, divisor, busy, done, quotient.
  - Instantiated twice, for x and y.

Test Plan:
- All bench cases use WIDTH=8, HEIGHT=4, MIN_PIXELS=4 (SUM_W=8). A frame is 32 pixels, sop on the first, eop on the last.
- **Square target:** frame with orange at (2,1),(3,1),(2,2),(3,2) -> pulse at T+10; target_found=1, pixel_count=4, centroid=(2,1), bbox x 2..3, y 1..2.
- **Below threshold:** frame with orange at (7,3) only -> pulse at T+2; target_found=0, pixel_count=1, centroid=0, bbox=0.
- **Valid gaps:** same frame as the square target, with pix_valid deasserted randomly 50% of cycles -> identical result to the square-target case.
- **Back-to-back frames:** square frame, then a frame with all 32 pixels orange -> two pulses. Second pulse: pixel_count=32, centroid=(3,1), bbox 0..7 / 0..3.
- **Overrun:** 4-pixel frame (sop...eop) with 4 orange pixels, immediately followed by another 4-pixel frame -> overrun pulses on the second eop+1; exactly one result_valid.
- **Reset:** reset asserted during DIVIDE -> all outputs 0, no pulse. A following full frame then produces the correct result.

Source files
------------

// File: rtl/target_locator_pkg.sv
// Shared sizing helpers and state type for the orange-target locator.
// Geometry defaults live here so the top and its users agree on them.
package target_locator_pkg;

    localparam int WIDTH_DEFAULT      = 320;
    localparam int HEIGHT_DEFAULT     = 240;
    localparam int MIN_PIXELS_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } div_state_t;

    function automatic int count_width(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

    // Sized on the larger axis so neither coordinate sum can wrap.
    function automatic int sum_width(input int w, input int h);
        longint m;
        m = (w > h) ? longint'(w) : longint'(h);
        return $clog2(longint'(w) * longint'(h) * (m - 1) + 1);
    endfunction

endpackage

// File: rtl/target_locator_divider.sv
// Restoring serial divider: one quotient bit per cycle, MSB first, W cycles.
// done is high during the final step, so quotient is complete on the following cycle.
module serial_divider #(
    parameter int W  = 8,
    parameter int DW = W,
    parameter int QW = W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  dvd;
    logic [W-1:0]  rem;
    logic [DW-1:0] dsr;
    logic [CW-1:0] steps;
    logic [W:0]    rem_shift;
    logic [W:0]    diff;

    // diff[W] is a valid sign bit because the partial remainder is always below 2*divisor.
    assign rem_shift = {rem, dvd[W-1]};
    assign diff      = rem_shift - (W+1)'(dsr);
    assign done      = busy && (steps == CW'(1));
    assign quotient  = dvd[QW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            steps <= '0;
            dvd   <= '0;
            rem   <= '0;
            dsr   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            steps <= CW'(W);
            dvd   <= dividend;
            rem   <= '0;
            dsr   <= divisor;
        end else if (busy) begin
            rem   <= diff[W] ? rem_shift[W-1:0] : diff[W-1:0];
            dvd   <= {dvd[W-2:0], ~diff[W]};
            steps <= steps - 1'b1;
            if (steps == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/target_locator.sv
// Per-frame orange-pixel statistics and centroid for the overlay/servo controller.
//   state  | meaning
//   IDLE   | waiting for an end-of-frame snapshot
//   DIVIDE | both centroid quotients being produced, one bit per cycle
//   DONE   | loading the result record and pulsing result_valid
module target_locator
    import target_locator_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEFAULT,
    parameter int HEIGHT     = HEIGHT_DEFAULT,
    parameter int MIN_PIXELS = MIN_PIXELS_DEFAULT,
    parameter int X_W        = $clog2(WIDTH),
    parameter int Y_W        = $clog2(HEIGHT),
    parameter int CNT_W      = count_width(WIDTH, HEIGHT),
    parameter int SUM_W      = sum_width(WIDTH, HEIGHT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic             pix_sop,
    input  logic             pix_eop,
    input  logic             is_orange,
    output logic             result_valid,
    output logic             target_found,
    output logic [X_W-1:0]   centroid_x,
    output logic [Y_W-1:0]   centroid_y,
    output logic [X_W-1:0]   bbox_x_min,
    output logic [X_W-1:0]   bbox_x_max,
    output logic [Y_W-1:0]   bbox_y_min,
    output logic [Y_W-1:0]   bbox_y_max,
    output logic [CNT_W-1:0] pixel_count,
    output logic             overrun
);

    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [SUM_W-1:0] sum_x;
        logic [SUM_W-1:0] sum_y;
        logic [X_W-1:0]   x_min;
        logic [X_W-1:0]   x_max;
        logic [Y_W-1:0]   y_min;
        logic [Y_W-1:0]   y_max;
    } accum_t;

    typedef struct packed {
        logic             found;
        logic [X_W-1:0]   cx;
        logic [Y_W-1:0]   cy;
        logic [X_W-1:0]   x_min;
        logic [X_W-1:0]   x_max;
        logic [Y_W-1:0]   y_min;
        logic [Y_W-1:0]   y_max;
        logic [CNT_W-1:0] count;
    } result_t;

    function automatic accum_t acc_clear();
        accum_t a;
        a       = '0;
        a.x_min = X_LAST;
        a.y_min = Y_LAST;
        return a;
    endfunction

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_y;
    accum_t         acc;
    accum_t         acc_base;
    accum_t         acc_next;
    accum_t         snap;
    logic           snap_pend;
    logic           snap_found;
    div_state_t     state;
    result_t        res;
    result_t        res_next;
    logic           frame_end;
    logic           div_busy;
    logic           div_start;
    logic           x_busy;
    logic           y_busy;
    logic           x_done;
    logic           y_done;
    logic [X_W-1:0] x_quot;
    logic [Y_W-1:0] y_quot;

    // x/y hold the coordinate the next non-sop pixel will take.
    always_comb begin
        cur_x    = pix_sop ? '0 : x;
        cur_y    = pix_sop ? '0 : y;
        acc_base = pix_sop ? acc_clear() : acc;
        acc_next = acc_base;
        if (is_orange) begin
            acc_next.count = acc_base.count + 1'b1;
            acc_next.sum_x = acc_base.sum_x + SUM_W'(cur_x);
            acc_next.sum_y = acc_base.sum_y + SUM_W'(cur_y);
            if (cur_x < acc_base.x_min) acc_next.x_min = cur_x;
            if (cur_x > acc_base.x_max) acc_next.x_max = cur_x;
            if (cur_y < acc_base.y_min) acc_next.y_min = cur_y;
            if (cur_y > acc_base.y_max) acc_next.y_max = cur_y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x   <= '0;
            y   <= '0;
            acc <= acc_clear();
        end else if (pix_valid) begin
            if (cur_x == X_LAST) begin
                x <= '0;
                y <= (cur_y == Y_LAST) ? cur_y : cur_y + 1'b1;
            end else begin
                x <= cur_x + 1'b1;
                y <= cur_y;
            end
            acc <= pix_eop ? acc_clear() : acc_next;
        end
    end

    assign frame_end  = pix_valid && pix_eop;
    assign div_busy   = (state != IDLE) || snap_pend || x_busy || y_busy;
    assign snap_found = snap.count >= CNT_W'(MIN_PIXELS);
    assign div_start  = (state == IDLE) && snap_pend && snap_found;

    always_comb begin
        res_next       = '0;
        res_next.count = snap.count;
        if (snap_found) begin
            res_next.found = 1'b1;
            res_next.cx    = x_quot;
            res_next.cy    = y_quot;
            res_next.x_min = snap.x_min;
            res_next.x_max = snap.x_max;
            res_next.y_min = snap.y_min;
            res_next.y_max = snap.y_max;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            snap         <= acc_clear();
            snap_pend    <= 1'b0;
            res          <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            overrun      <= frame_end && div_busy;
            if (frame_end && !div_busy) begin
                snap      <= acc_next;
                snap_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (snap_pend) begin
                        snap_pend <= 1'b0;
                        state     <= snap_found ? DIVIDE : DONE;
                    end
                end
                DIVIDE: begin
                    if (x_done && y_done) state <= DONE;
                end
                DONE: begin
                    state        <= IDLE;
                    res          <= res_next;
                    result_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    serial_divider #(.W(SUM_W), .DW(CNT_W), .QW(X_W)) u_div_x (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (snap.sum_x),
        .divisor  (snap.count),
        .busy     (x_busy),
        .done     (x_done),
        .quotient (x_quot)
    );

    serial_divider #(.W(SUM_W), .DW(CNT_W), .QW(Y_W)) u_div_y (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (snap.sum_y),
        .divisor  (snap.count),
        .busy     (y_busy),
        .done     (y_done),
        .quotient (y_quot)
    );

    assign target_found = res.found;
    assign centroid_x   = res.cx;
    assign centroid_y   = res.cy;
    assign bbox_x_min   = res.x_min;
    assign bbox_x_max   = res.x_max;
    assign bbox_y_min   = res.y_min;
    assign bbox_y_max   = res.y_max;
    assign pixel_count  = res.count;

endmodule

// File: tb/tb_target_locator.sv
// Bench for target_locator on an 8x4 frame: frame-level reference model checked every cycle,
// plus literal expectations for the directed cases.
module tb_target_locator;

    localparam int WIDTH      = 8;
    localparam int HEIGHT     = 4;
    localparam int MIN_PIXELS = 4;
    localparam int SUM_W      = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_valid;
    logic       pix_sop;
    logic       pix_eop;
    logic       is_orange;
    logic       result_valid;
    logic       target_found;
    logic [2:0] centroid_x;
    logic [1:0] centroid_y;
    logic [2:0] bbox_x_min;
    logic [2:0] bbox_x_max;
    logic [1:0] bbox_y_min;
    logic [1:0] bbox_y_max;
    logic [5:0] pixel_count;
    logic       overrun;

    always #5 clk = ~clk;

    target_locator #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .MIN_PIXELS(MIN_PIXELS)) dut (
        .clk          (clk),
        .reset        (reset),
        .pix_valid    (pix_valid),
        .pix_sop      (pix_sop),
        .pix_eop      (pix_eop),
        .is_orange    (is_orange),
        .result_valid (result_valid),
        .target_found (target_found),
        .centroid_x   (centroid_x),
        .centroid_y   (centroid_y),
        .bbox_x_min   (bbox_x_min),
        .bbox_x_max   (bbox_x_max),
        .bbox_y_min   (bbox_y_min),
        .bbox_y_max   (bbox_y_max),
        .pixel_count  (pixel_count),
        .overrun      (overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level reference model
    typedef struct {
        int found, cnt, cx, cy, xmin, xmax, ymin, ymax;
    } rec_t;
    typedef struct {
        int   due;
        rec_t rec;
    } pend_t;

    pend_t pq[$];
    rec_t  cur;
    rec_t  r;
    int    cyc = 0;
    int    busy_until = 0;
    int    ovr_at = -1;
    bit    live = 0;
    bit    exp_rv;
    int    f_idx, f_cnt, f_sx, f_sy, f_xmin, f_xmax, f_ymin, f_ymax, px, py, lat_m;

    function automatic void frame_clear();
        f_cnt = 0; f_sx = 0; f_sy = 0;
        f_xmin = 1000; f_xmax = -1; f_ymin = 1000; f_ymax = -1;
    endfunction

    initial begin
        frame_clear();
        f_idx = 0;
        cur = '{default: 0};
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                live = 1;
                pq.delete();
                busy_until = 0;
                ovr_at = -1;
                cur = '{default: 0};
                frame_clear();
                f_idx = 0;
            end else if (pix_valid) begin
                if (pix_sop) begin
                    frame_clear();
                    f_idx = 0;
                end
                if (is_orange) begin
                    px = f_idx % WIDTH;
                    py = f_idx / WIDTH;
                    if (py > HEIGHT - 1) py = HEIGHT - 1;
                    f_cnt++; f_sx += px; f_sy += py;
                    if (px < f_xmin) f_xmin = px;
                    if (px > f_xmax) f_xmax = px;
                    if (py < f_ymin) f_ymin = py;
                    if (py > f_ymax) f_ymax = py;
                end
                f_idx++;
                if (pix_eop) begin
                    if (cyc > busy_until) begin
                        r = '{default: 0};
                        r.cnt = f_cnt;
                        if (f_cnt >= MIN_PIXELS) begin
                            r.found = 1;
                            r.cx = f_sx / f_cnt; r.cy = f_sy / f_cnt;
                            r.xmin = f_xmin; r.xmax = f_xmax;
                            r.ymin = f_ymin; r.ymax = f_ymax;
                            lat_m = 2 + SUM_W;
                        end else begin
                            lat_m = 2;
                        end
                        pq.push_back('{due: cyc + lat_m, rec: r});
                        busy_until = cyc + lat_m;
                    end else begin
                        ovr_at = cyc;
                    end
                    frame_clear();
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                exp_rv = (pq.size() > 0) && (pq[0].due == cyc);
                if (exp_rv) begin
                    cur = pq[0].rec;
                    void'(pq.pop_front());
                end
                chk("m_result_valid", result_valid, exp_rv);
                chk("m_overrun", overrun, ovr_at == cyc);
                chk("m_found", target_found, cur.found);
                chk("m_count", pixel_count, cur.cnt);
                chk("m_cx", centroid_x, cur.cx);
                chk("m_cy", centroid_y, cur.cy);
                chk("m_xmin", bbox_x_min, cur.xmin);
                chk("m_xmax", bbox_x_max, cur.xmax);
                chk("m_ymin", bbox_y_min, cur.ymin);
                chk("m_ymax", bbox_y_max, cur.ymax);
            end
        end
    end

    // Stimulus helpers (called at a negedge, return at a negedge)
    task automatic drive(input bit sop, input bit eop, input bit org);
        pix_valid = 1'b1; pix_sop = sop; pix_eop = eop; is_orange = org;
        @(negedge clk);
        pix_valid = 1'b0; pix_sop = 1'b0; pix_eop = 1'b0; is_orange = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [63:0] mask, input int gap, input bit with_eop);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 8 && $urandom_range(99) < gap; g++) @(negedge clk);
            drive(i == 0, with_eop && (i == n - 1), mask[i]);
        end
    endtask

    task automatic wait_pulse(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (result_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_out(input string tag, input int found, input int cnt, input int cx, input int cy,
                             input int xmin, input int xmax, input int ymin, input int ymax);
        chk({tag, "_found"}, target_found, found);
        chk({tag, "_count"}, pixel_count, cnt);
        chk({tag, "_cx"}, centroid_x, cx);
        chk({tag, "_cy"}, centroid_y, cy);
        chk({tag, "_xmin"}, bbox_x_min, xmin);
        chk({tag, "_xmax"}, bbox_x_max, xmax);
        chk({tag, "_ymin"}, bbox_y_min, ymin);
        chk({tag, "_ymax"}, bbox_y_max, ymax);
    endtask

    localparam logic [63:0] SQUARE = 64'h0000_0000_000C_0C00;
    localparam logic [63:0] CORNER = 64'h0000_0000_8000_0000;
    localparam logic [63:0] ALL    = 64'hFFFF_FFFF_FFFF_FFFF;

    int lat;
    int n_rv;
    int n_ovr;

    initial begin
        reset = 1'b1; pix_valid = 1'b0; pix_sop = 1'b0; pix_eop = 1'b0; is_orange = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_out("rst", 0, 0, 0, 0, 0, 0, 0, 0);

        send_frame(32, SQUARE, 0, 1);
        wait_pulse(lat);
        chk("square_latency", lat, 10);
        check_out("square", 1, 4, 2, 1, 2, 3, 1, 2);

        send_frame(32, CORNER, 0, 1);
        wait_pulse(lat);
        chk("below_latency", lat, 2);
        check_out("below", 0, 1, 0, 0, 0, 0, 0, 0);

        send_frame(32, SQUARE, 50, 1);
        wait_pulse(lat);
        chk("gaps_latency", lat, 10);
        check_out("gaps", 1, 4, 2, 1, 2, 3, 1, 2);

        // Back-to-back: second frame starts right after the first eop
        send_frame(32, SQUARE, 0, 1);
        send_frame(32, ALL, 0, 1);
        wait_pulse(lat);
        chk("b2b_latency", lat, 10);
        check_out("b2b", 1, 32, 3, 1, 0, 7, 0, 3);

        // Second short frame ends while the first is still dividing
        n_ovr = 0; n_rv = 0;
        send_frame(4, 64'hF, 0, 1);
        send_frame(4, 64'hF, 0, 1);
        if (overrun) n_ovr++;
        if (result_valid) n_rv++;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (overrun) n_ovr++;
            if (result_valid) n_rv++;
        end
        chk("ovr_pulses", n_ovr, 1);
        chk("ovr_results", n_rv, 1);
        check_out("ovr", 1, 4, 1, 0, 0, 3, 0, 0);

        // Single-pixel frame with sop and eop together
        drive(1'b1, 1'b1, 1'b1);
        wait_pulse(lat);
        chk("one_px_latency", lat, 2);
        check_out("one_px", 0, 1, 0, 0, 0, 0, 0, 0);

        // Unfinished frame discarded by a new sop
        send_frame(10, ALL, 0, 0);
        send_frame(32, SQUARE, 0, 1);
        wait_pulse(lat);
        chk("restart_latency", lat, 10);
        check_out("restart", 1, 4, 2, 1, 2, 3, 1, 2);

        // 40-pixel frame: rows past the last one stay on row 3
        send_frame(40, ALL, 0, 1);
        wait_pulse(lat);
        check_out("ysat", 1, 40, 3, 1, 0, 7, 0, 3);

        // Reset during DIVIDE
        send_frame(32, SQUARE, 0, 1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_out("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
        n_rv = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (result_valid) n_rv++;
        end
        chk("midrst_no_pulse", n_rv, 0);
        send_frame(32, ALL, 0, 1);
        wait_pulse(lat);
        chk("after_rst_latency", lat, 10);
        check_out("after_rst", 1, 32, 3, 1, 0, 7, 0, 3);

        repeat (5) @(negedge clk);
        chk("model_queue_empty", pq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
